storage_arbiter: RTL and testbench
==================================

Name: storage_arbiter

Overview:
- Round-robin controller that shares one 8-bit LIFO/FIFO/BUFFER storage engine between NUM_REQ requesters.
- Serialises requests and drives the engine's mode, chip-enable, push and pop inputs, then returns the popped or passed data to the granted requester.
- Tracks occupancy and mode lock itself, so illegal operations are rejected before they reach the engine.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
DATA_W, 8, data width
DEPTH, 15, usable storage entries; must match the engine's limit

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
req  in  NUM_REQ  request per requester; held until gnt
req_op  in  NUM_REQ  per requester: 0 = push, 1 = pop
req_mode  in  2*NUM_REQ  per requester mode: 0 LIFO, 1 FIFO, 2 BUFFER
req_data  in  DATA_W*NUM_REQ  per-requester push/buffer data
gnt  out  NUM_REQ  one-hot, one-cycle grant pulse
rsp_valid  out  1  one-cycle response strobe
rsp_id  out  3  index of the requester being answered
rsp_data  out  DATA_W  popped or buffered data; 0 on error
rsp_err  out  1  operation rejected
st_mode  out  2  engine mode select
st_chip_en_lifo / st_chip_en_fifo / st_chip_en_buffer  out  1 each  engine enables
st_push, st_pop  out  1 each  engine strobes
st_din  out  DATA_W  engine data in
st_dout  in  DATA_W  engine registered data out
occupancy  out  4  current entry count (0..DEPTH)

Behaviour:
- Reset: clock is clk. Reset is asynchronous and active-high on port reset. On reset, all outputs go to 0, state = IDLE, rr pointer = 0, occupancy = 0, lock_mode = LIFO. Reset mid-operation abandons the operation with no response. The engine shares the same reset.
- All outputs are registered.
- FSM states: IDLE, ISSUE, WAIT.
- IDLE:
  - If any req is set, pick the first set bit searching upward from the rr pointer (wrapping).
  - At that edge: latch id, op, mode and data; pulse gnt[id]; set pointer = (id+1) mod NUM_REQ; evaluate legality; go to ISSUE.
  - If no req is set, stay in IDLE.
- Legality, evaluated in this order:
  - mode 3 -> reject.
  - BUFFER -> always legal; op is ignored; occupancy is unchanged.
  - occupancy != 0 and mode != lock_mode -> reject.
  - push with occupancy == DEPTH -> reject.
  - pop with occupancy == 0 -> reject.
- ISSUE (one cycle):
  - Drive st_mode = latched mode, the matching chip_en = 1, st_din = latched data.
  - Legal LIFO/FIFO push: st_push = 1. Legal pop: st_pop = 1. Rejected ops and BUFFER: no strobes.
  - Chip_en stays asserted through WAIT.
  - At the edge leaving ISSUE: occupancy +1 on a legal push, -1 on a legal pop. lock_mode takes the latched mode on a legal push when occupancy was 0. Go to WAIT.
- WAIT (one cycle): at its closing edge, pulse rsp_valid and load rsp_id and rsp_err.
  - rsp_data = st_dout for a legal pop or BUFFER.
  - rsp_data = 0 for a push or a reject.
  - Then clear strobes and enables, and go to IDLE.
- Timing: gnt at edge N, rsp_valid at edge N+2, next grant at earliest edge N+3. One operation per 3 cycles.
- A requester must drop req in the cycle after gnt; a still-high req at the next IDLE is a new request.
- Simultaneous requests are served strictly round-robin; there is no starvation with NUM_REQ ≤ 8.
- Occupancy never wraps: it saturates by rejection, not by arithmetic.

Decomposition:
- Package storage_arb_pkg holds:
  - mode constants LIFO=0, FIFO=1, BUFFER=2, MODE_INVALID=3;
  - op constants OP_PUSH=0, OP_POP=1;
  - the FSM state enum.
- Sub-module rr_picker: combinational; inputs req vector and pointer; outputs one-hot winner, binary index and any_req.

Test Plan:
- Reset, then requester 0 pushes 0x11, 0x22, 0x33 in FIFO; requester 2 pops 3 times -> rsp_data 0x11, 0x22, 0x33, rsp_err = 0, occupancy ends at 0.
- LIFO: push 0xA1, 0xA2, then pop -> 0xA2; pop again -> 0xA1; third pop -> rsp_err = 1, rsp_data = 0, no st_pop pulse.
- req = 4'b1111 held (re-raised after each gnt) -> grant order 0,1,2,3,0; each gnt followed by rsp_valid exactly 2 cycles later.
- FIFO occupancy 2, requester 1 pushes in LIFO mode -> rsp_err = 1, occupancy stays 2; BUFFER request with data 0x5A -> rsp_data = 0x5A, occupancy stays 2.
- 15 legal pushes, then a 16th push -> rsp_err = 1, occupancy = 15, no st_push pulse.
- Assert reset during ISSUE of a push -> all outputs 0 immediately, no rsp_valid, occupancy 0, next grant goes to requester 0.

Source files
------------

// File: rtl/storage_arb_pkg.sv
// Shared constants and state encoding for the storage arbiter slice.
package storage_arb_pkg;

  localparam logic [1:0] LIFO         = 2'd0;
  localparam logic [1:0] FIFO         = 2'd1;
  localparam logic [1:0] BUFFER       = 2'd2;
  localparam logic [1:0] MODE_INVALID = 2'd3;

  localparam logic OP_PUSH = 1'b0;
  localparam logic OP_POP  = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_e;

endpackage

// File: rtl/storage_arbiter_if.sv
// Requester-side bundle: per-requester request fields in, grant and response out.
interface storage_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8
);
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ-1:0]        req_op;
  logic [2*NUM_REQ-1:0]      req_mode;
  logic [DATA_W*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]        gnt;
  logic                      rsp_valid;
  logic [2:0]                rsp_id;
  logic [DATA_W-1:0]         rsp_data;
  logic                      rsp_err;

  modport master (
    output req, req_op, req_mode, req_data,
    input  gnt, rsp_valid, rsp_id, rsp_data, rsp_err
  );

  modport slave (
    input  req, req_op, req_mode, req_data,
    output gnt, rsp_valid, rsp_id, rsp_data, rsp_err
  );
endinterface

// File: rtl/rr_picker.sv
// Combinational round-robin pick: first set request at or above ptr, wrapping.
module rr_picker #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 3
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] winner,
  output logic [IDX_W-1:0]   idx,
  output logic               any_req
);
  logic [NUM_REQ-1:0] rot;

  always_comb begin
    // rot[k] is the request k places above the pointer; scanning downward
    // leaves the nearest one as the final assignment.
    rot     = NUM_REQ'({req, req} >> ptr);
    winner  = '0;
    idx     = '0;
    any_req = |req;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (rot[k]) begin
        idx    = IDX_W'((int'(ptr) + k) % NUM_REQ);
        winner = NUM_REQ'(1) << idx;
      end
    end
  end
endmodule

// File: rtl/storage_arbiter.sv
// Round-robin front end for a shared LIFO/FIFO/BUFFER engine: grants one
// requester at a time, filters illegal ops, and returns the engine's answer.
module storage_arbiter
  import storage_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8,
  parameter int DEPTH   = 15
) (
  input  logic              clk,
  input  logic              reset,
  storage_arbiter_if.slave  bus,
  output logic [1:0]        st_mode,
  output logic              st_chip_en_lifo,
  output logic              st_chip_en_fifo,
  output logic              st_chip_en_buffer,
  output logic              st_push,
  output logic              st_pop,
  output logic [DATA_W-1:0] st_din,
  input  logic [DATA_W-1:0] st_dout,
  output logic [3:0]        occupancy
);
  localparam int IDX_W = 3;

  state_e             state;
  logic [IDX_W-1:0]   ptr;
  logic [IDX_W-1:0]   id_q;
  logic               op_q;
  logic               legal_q;
  logic [1:0]         mode_q;
  logic [1:0]         lock_mode;

  logic [NUM_REQ-1:0] win_oh;
  logic [IDX_W-1:0]   win_idx;
  logic               any_req;
  logic [1:0]         sel_mode;
  logic               sel_op;
  logic [DATA_W-1:0]  sel_data;
  logic               sel_legal;

  function automatic logic op_legal(input logic [1:0] mode, input logic op,
                                    input logic [3:0] occ, input logic [1:0] lock);
    logic ok;
    if (mode == MODE_INVALID)                 ok = 1'b0;
    else if (mode == BUFFER)                  ok = 1'b1;
    else if (occ != 4'd0 && mode != lock)     ok = 1'b0;
    else if (op == OP_PUSH)                   ok = (occ != 4'(DEPTH));
    else                                      ok = (occ != 4'd0);
    return ok;
  endfunction

  function automatic logic [IDX_W-1:0] next_ptr(input logic [IDX_W-1:0] idx);
    if (int'(idx) == NUM_REQ - 1) return '0;
    return idx + 1'b1;
  endfunction

  rr_picker #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_picker (
    .req     (bus.req),
    .ptr     (ptr),
    .winner  (win_oh),
    .idx     (win_idx),
    .any_req (any_req)
  );

  always_comb begin
    sel_mode = '0;
    sel_op   = 1'b0;
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win_oh[i]) begin
        sel_mode = bus.req_mode[2*i +: 2];
        sel_op   = bus.req_op[i];
        sel_data = bus.req_data[DATA_W*i +: DATA_W];
      end
    end
    sel_legal = op_legal(sel_mode, sel_op, occupancy, lock_mode);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state             <= ST_IDLE;
      ptr               <= '0;
      id_q              <= '0;
      op_q              <= 1'b0;
      legal_q           <= 1'b0;
      mode_q            <= LIFO;
      lock_mode         <= LIFO;
      occupancy         <= '0;
      bus.gnt           <= '0;
      bus.rsp_valid     <= 1'b0;
      bus.rsp_id        <= '0;
      bus.rsp_data      <= '0;
      bus.rsp_err       <= 1'b0;
      st_mode           <= '0;
      st_chip_en_lifo   <= 1'b0;
      st_chip_en_fifo   <= 1'b0;
      st_chip_en_buffer <= 1'b0;
      st_push           <= 1'b0;
      st_pop            <= 1'b0;
      st_din            <= '0;
    end else begin
      bus.gnt       <= '0;
      bus.rsp_valid <= 1'b0;
      case (state)
        // IDLE -> ISSUE: grant, latch the request and set up the engine for ISSUE
        ST_IDLE: begin
          if (any_req) begin
            bus.gnt           <= win_oh;
            id_q              <= win_idx;
            op_q              <= sel_op;
            mode_q            <= sel_mode;
            legal_q           <= sel_legal;
            ptr               <= next_ptr(win_idx);
            st_mode           <= sel_mode;
            st_chip_en_lifo   <= (sel_mode == LIFO);
            st_chip_en_fifo   <= (sel_mode == FIFO);
            st_chip_en_buffer <= (sel_mode == BUFFER);
            st_din            <= sel_data;
            st_push           <= sel_legal && sel_mode != BUFFER && sel_op == OP_PUSH;
            st_pop            <= sel_legal && sel_mode != BUFFER && sel_op == OP_POP;
            state             <= ST_ISSUE;
          end
        end
        // ISSUE -> WAIT: engine consumes the strobe; bookkeeping follows it
        ST_ISSUE: begin
          st_push <= 1'b0;
          st_pop  <= 1'b0;
          if (st_push) begin
            occupancy <= occupancy + 4'd1;
            if (occupancy == 4'd0) lock_mode <= mode_q;
          end else if (st_pop) begin
            occupancy <= occupancy - 4'd1;
          end
          state <= ST_WAIT;
        end
        // WAIT -> IDLE: engine output is now registered, answer the requester
        ST_WAIT: begin
          bus.rsp_valid     <= 1'b1;
          bus.rsp_id        <= id_q;
          bus.rsp_err       <= ~legal_q;
          bus.rsp_data      <= (legal_q && (mode_q == BUFFER || op_q == OP_POP)) ? st_dout : '0;
          st_mode           <= '0;
          st_chip_en_lifo   <= 1'b0;
          st_chip_en_fifo   <= 1'b0;
          st_chip_en_buffer <= 1'b0;
          st_din            <= '0;
          state             <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_storage_arbiter.sv
// Scoreboard bench for storage_arbiter with a behavioural engine stub and a
// queue-based reference model of arbitration and storage legality.
module tb_storage_arbiter;
  import storage_arb_pkg::*;

  localparam int NR    = 4;
  localparam int DW    = 8;
  localparam int DEPTH = 15;

  typedef struct {
    logic       op;
    logic [1:0] mode;
    logic [7:0] data;
  } item_t;

  typedef struct {
    int         id;
    logic       err;
    logic [7:0] data;
    int         due;
    int         occ;
    int         epush;
    int         epop;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [1:0]    st_mode;
  logic          st_chip_en_lifo, st_chip_en_fifo, st_chip_en_buffer;
  logic          st_push, st_pop;
  logic [DW-1:0] st_din;
  logic [DW-1:0] st_dout;
  logic [3:0]    occupancy;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int npush    = 0;
  int npop     = 0;

  item_t      stim_q[NR][$];
  exp_t       exp_q[$];
  int         gnt_log[$];
  logic [7:0] m_store[$];
  logic [1:0] m_lock = LIFO;
  int         m_ptr  = 0;
  logic [7:0] eng_q[$];

  storage_arbiter_if #(.NUM_REQ(NR), .DATA_W(DW)) bus ();

  storage_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .DEPTH(DEPTH)) dut (
    .clk               (clk),
    .reset             (reset),
    .bus               (bus),
    .st_mode           (st_mode),
    .st_chip_en_lifo   (st_chip_en_lifo),
    .st_chip_en_fifo   (st_chip_en_fifo),
    .st_chip_en_buffer (st_chip_en_buffer),
    .st_push           (st_push),
    .st_pop            (st_pop),
    .st_din            (st_din),
    .st_dout           (st_dout),
    .occupancy         (occupancy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Engine stub: one shared store, registered output.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      eng_q.delete();
      st_dout <= '0;
    end else begin
      if (st_chip_en_buffer) st_dout <= st_din;
      if (st_push && eng_q.size() < DEPTH) eng_q.push_back(st_din);
      if (st_pop && eng_q.size() > 0) begin
        if (st_mode == FIFO) st_dout <= eng_q.pop_front();
        else                 st_dout <= eng_q.pop_back();
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic add(input int i, input logic op, input logic [1:0] md, input logic [7:0] d);
    item_t it;
    it.op = op; it.mode = md; it.data = d;
    stim_q[i].push_back(it);
  endtask

  task automatic raise(input int i, input item_t it);
    bus.req_op   = (bus.req_op & ~(4'b1 << i)) | (4'(it.op) << i);
    bus.req_mode = (bus.req_mode & ~(8'h3 << (2*i))) | (8'(it.mode) << (2*i));
    bus.req_data = (bus.req_data & ~(32'hFF << (8*i))) | (32'(it.data) << (8*i));
    bus.req      = bus.req | (4'b1 << i);
  endtask

  function automatic bit stim_empty();
    for (int i = 0; i < NR; i++) if (stim_q[i].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  // Reference model: evaluated when a grant is observed, result goes to the scoreboard.
  task automatic handle_grant(output int win);
    exp_t       e;
    logic [1:0] md;
    logic       op;
    logic [7:0] dt;
    win = -1;
    for (int k = 0; k < NR; k++) begin
      int c;
      c = (m_ptr + k) % NR;
      if (((bus.req >> c) & 4'b1) != 4'b0) begin win = c; break; end
    end
    if (win < 0) begin
      n_checks++;
      $display("FAIL gnt_without_req: got 0x%0h, expected no grant", bus.gnt);
      return;
    end
    check("gnt_winner", 32'(bus.gnt), 32'(4'b1 << win));
    gnt_log.push_back(win);
    m_ptr = (win + 1) % NR;
    md = 2'(bus.req_mode >> (2*win));
    op = 1'(bus.req_op >> win);
    dt = 8'(bus.req_data >> (8*win));
    e.id = win; e.due = cyc + 2; e.err = 1'b0; e.data = 8'h00; e.epush = 0; e.epop = 0;
    if (md == MODE_INVALID) e.err = 1'b1;
    else if (md == BUFFER) e.data = dt;
    else if (m_store.size() != 0 && md != m_lock) e.err = 1'b1;
    else if (op == OP_PUSH) begin
      if (m_store.size() == DEPTH) e.err = 1'b1;
      else begin
        if (m_store.size() == 0) m_lock = md;
        m_store.push_back(dt);
        e.epush = 1;
      end
    end else begin
      if (m_store.size() == 0) e.err = 1'b1;
      else begin
        e.epop = 1;
        if (md == FIFO) e.data = m_store.pop_front();
        else            e.data = m_store.pop_back();
      end
    end
    e.occ = m_store.size();
    exp_q.push_back(e);
    bus.req = bus.req & ~(4'b1 << win);
  endtask

  task automatic run(input int budget);
    int         start;
    int         w;
    bit         done;
    logic [3:0] gnow;
    start = cyc;
    done  = 1'b0;
    while (!done) begin
      @(negedge clk);
      gnow = '0;
      if (bus.gnt != 0) begin
        handle_grant(w);
        if (w >= 0) gnow = 4'b1 << w;
      end
      for (int i = 0; i < NR; i++)
        if (((bus.req | gnow) >> i & 4'b1) == 4'b0 && stim_q[i].size() > 0)
          raise(i, stim_q[i].pop_front());
      done = (bus.req == 0) && (exp_q.size() == 0) && stim_empty();
      if (!done && cyc - start > budget) begin
        n_checks++;
        $display("FAIL run_budget: %0d cycles elapsed, limit %0d", cyc - start, budget);
        bus.req = '0;
        for (int i = 0; i < NR; i++) stim_q[i].delete();
        done = 1'b1;
      end
    end
  endtask

  // Monitor: pulse accounting and response checking against the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus.gnt != 0) begin
        npush = int'(st_push);
        npop  = int'(st_pop);
      end else begin
        npush += int'(st_push);
        npop  += int'(st_pop);
      end
      if (bus.rsp_valid) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_rsp: got id %0d, expected no response", bus.rsp_id);
        end else begin
          e = exp_q.pop_front();
          check("rsp_id", 32'(bus.rsp_id), e.id);
          check("rsp_err", 32'(bus.rsp_err), 32'(e.err));
          check("rsp_data", 32'(bus.rsp_data), 32'(e.data));
          check("rsp_latency", cyc, e.due);
          check("occupancy", 32'(occupancy), e.occ);
          check("st_push_pulses", npush, e.epush);
          check("st_pop_pulses", npop, e.epop);
        end
      end else if (exp_q.size() > 0 && cyc > exp_q[0].due) begin
        n_checks++;
        $display("FAIL missing_rsp: got none by cycle %0d, expected at %0d", cyc, exp_q[0].due);
        void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_gnt"}, 32'(bus.gnt), 0);
    check({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 0);
    check({tag, "_rsp_data"}, 32'(bus.rsp_data), 0);
    check({tag, "_occupancy"}, 32'(occupancy), 0);
    check({tag, "_enables"}, 32'({st_chip_en_lifo, st_chip_en_fifo, st_chip_en_buffer}), 0);
    check({tag, "_strobes"}, 32'({st_push, st_pop}), 0);
    check({tag, "_st_mode_din"}, 32'({st_mode, st_din}), 0);
  endtask

  initial begin
    int t;
    bus.req = '0; bus.req_op = '0; bus.req_mode = '0; bus.req_data = '0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    reset = 1'b0;

    // All four requesting: strict rotation 0,1,2,3,0
    gnt_log.delete();
    add(0, OP_PUSH, BUFFER, 8'hB0); add(0, OP_POP, BUFFER, 8'hB4);
    add(1, OP_PUSH, BUFFER, 8'hB1); add(2, OP_POP, BUFFER, 8'hB2); add(3, OP_PUSH, BUFFER, 8'hB3);
    run(200);
    check("rr_count", gnt_log.size(), 5);
    for (int i = 0; i < 5 && i < gnt_log.size(); i++) check("rr_order", gnt_log[i], i % NR);

    // FIFO round trip
    add(0, OP_PUSH, FIFO, 8'h11); add(0, OP_PUSH, FIFO, 8'h22); add(0, OP_PUSH, FIFO, 8'h33);
    run(200);
    check("fifo_fill_occ", 32'(occupancy), 3);
    repeat (3) add(2, OP_POP, FIFO, 8'h00);
    run(200);
    check("fifo_drain_occ", 32'(occupancy), 0);

    // LIFO with an underflowing third pop
    add(0, OP_PUSH, LIFO, 8'hA1); add(0, OP_PUSH, LIFO, 8'hA2);
    run(200);
    repeat (3) add(3, OP_POP, LIFO, 8'h00);
    run(200);
    check("lifo_occ", 32'(occupancy), 0);

    // Mode lock rejection and BUFFER pass-through with data held
    add(0, OP_PUSH, FIFO, 8'h41); add(0, OP_PUSH, FIFO, 8'h42);
    run(200);
    add(1, OP_PUSH, LIFO, 8'h99);
    run(200);
    check("lock_reject_occ", 32'(occupancy), 2);
    add(3, OP_POP, BUFFER, 8'h5A);
    run(200);
    check("buffer_occ", 32'(occupancy), 2);
    add(0, OP_PUSH, MODE_INVALID, 8'h66);
    repeat (2) add(0, OP_POP, FIFO, 8'h00);
    run(200);
    check("mode3_drain_occ", 32'(occupancy), 0);

    // Fill to DEPTH then overflow
    for (int i = 0; i < 16; i++) add(2, OP_PUSH, LIFO, 8'(8'h80 + i));
    run(400);
    check("full_occ", 32'(occupancy), 15);
    for (int i = 0; i < 15; i++) add(1, OP_POP, LIFO, 8'h00);
    run(400);
    check("empty_occ", 32'(occupancy), 0);

    // Reset during ISSUE of a push
    add(0, OP_PUSH, LIFO, 8'h31); add(0, OP_PUSH, LIFO, 8'h32);
    run(200);
    check("prefill_occ", 32'(occupancy), 2);
    @(negedge clk);
    begin
      item_t it;
      it.op = OP_PUSH; it.mode = LIFO; it.data = 8'h77;
      raise(1, it);
    end
    t = 0;
    @(negedge clk);
    while (bus.gnt == 0 && t < 10) begin @(negedge clk); t++; end
    check("midop_gnt", 32'(bus.gnt), 32'(4'b0010));
    bus.req = '0;
    reset = 1'b1;
    #1;
    check_all_zero("midop_reset");
    m_store.delete(); m_ptr = 0; m_lock = LIFO;
    repeat (2) @(negedge clk);
    check("reset_no_rsp", 32'(bus.rsp_valid), 0);
    reset = 1'b0;
    gnt_log.delete();
    add(0, OP_PUSH, BUFFER, 8'hC0); add(2, OP_PUSH, BUFFER, 8'hC2);
    run(200);
    check("post_reset_first_gnt", (gnt_log.size() > 0) ? gnt_log[0] : -1, 0);

    // Randomized mix across all requesters
    for (int n = 0; n < 200; n++) begin
      int         r;
      logic [1:0] md;
      r  = int'($urandom_range(0, 9));
      md = (r < 4) ? LIFO : (r < 8) ? FIFO : (r < 9) ? BUFFER : MODE_INVALID;
      add(int'($urandom_range(0, NR - 1)), ($urandom_range(0, 9) < 6) ? OP_PUSH : OP_POP,
          md, 8'($urandom_range(0, 255)));
    end
    run(3000);
    check("random_occ", 32'(occupancy), m_store.size());

    repeat (4) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
